// File: rtl/ex_result_if.sv
// ex_result_if: result handshake between ex_stage (master) and ex_result_pipe (slave).
// master drives in_valid/payload/flush/out_ready; slave returns in_ready, the head entry
// (out_valid/out_result/out_rd/out_reg_write) and the committed flags flag_z/flag_c.
interface ex_result_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned REGW  = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] alu_result;
  logic             Z;
  logic             C;
  logic [REGW-1:0]  rd;
  logic             reg_write;
  logic             set_flags;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [REGW-1:0]  out_rd;
  logic             out_reg_write;
  logic             flag_z;
  logic             flag_c;

  modport master (
    output in_valid, alu_result, Z, C, rd, reg_write, set_flags, flush, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_reg_write, flag_z, flag_c
  );

  modport slave (
    input  in_valid, alu_result, Z, C, rd, reg_write, set_flags, flush, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_reg_write, flag_z, flag_c
  );
endinterface

// File: rtl/ex_result_pipe.sv
// ex_result_pipe: 2-entry skid buffer for ex_stage results plus the architectural Z/C
// flag register, which updates only when a set_flags entry is popped by write-back.
// Ports: clk, rst (sync, active-high), bus (ex_result_if.slave: input handshake + payload,
// flush, output handshake + head entry, committed flags).
module ex_result_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned REGW  = 4
) (
  input  logic        clk,
  input  logic        rst,
  ex_result_if.slave  bus
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             z;
    logic             c;
    logic [REGW-1:0]  rd;
    logic             reg_write;
    logic             set_flags;
  } entry_t;

  entry_t     head_q, head_d;
  entry_t     skid_q, skid_d;
  entry_t     in_entry;
  logic [1:0] count_q, count_d;
  logic       out_valid_q, out_valid_d;
  logic       flag_z_q, flag_z_d;
  logic       flag_c_q, flag_c_d;
  logic       push;
  logic       pop;

  // Input-side ready depends only on occupancy, so a pop at count=2 frees a slot next cycle.
  assign bus.in_ready = (count_q != 2'd2) && !rst;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = out_valid_q && bus.out_ready;

  // Pack the incoming payload.
  always_comb begin
    in_entry           = '0;
    in_entry.result    = bus.alu_result;
    in_entry.z         = bus.Z;
    in_entry.c         = bus.C;
    in_entry.rd        = bus.rd;
    in_entry.reg_write = bus.reg_write;
    in_entry.set_flags = bus.set_flags;
  end

  // Next-state: flush beats push/pop; head is always slot 0, skid holds the second entry.
  always_comb begin
    head_d   = head_q;
    skid_d   = skid_q;
    count_d  = count_q;
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;

    if (bus.flush) begin
      count_d = 2'd0;
    end else begin
      if (pop && head_q.set_flags) begin
        flag_z_d = head_q.z;
        flag_c_d = head_q.c;
      end
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_d = in_entry;
          else                 skid_d = in_entry;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = skid_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // push implies count<2, so count is 1 here: incoming entry replaces the head.
          head_d = in_entry;
        end
        default: ;
      endcase
    end

    out_valid_d = (count_d != 2'd0);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      skid_q      <= '0;
      count_q     <= 2'd0;
      out_valid_q <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_c_q    <= 1'b0;
    end else begin
      head_q      <= head_d;
      skid_q      <= skid_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      flag_z_q    <= flag_z_d;
      flag_c_q    <= flag_c_d;
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.out_result    = head_q.result;
  assign bus.out_rd        = head_q.rd;
  assign bus.out_reg_write = head_q.reg_write;
  assign bus.flag_z        = flag_z_q;
  assign bus.flag_c        = flag_c_q;

endmodule
